// File: rtl/bus_arbiter_nm.sv
// N-master bus arbiter (fixed-priority or round-robin) with serial slave address and one-level split.
// Grant lands ADDR_BITS-1 edges after acceptance; requesters wait (hold m_request) until granted.
module bus_arbiter_nm #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int ADDR_BITS   = 2,
    parameter int RR_MODE     = 0,
    localparam int GW = $clog2(NUM_MASTERS + 1)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [NUM_MASTERS-1:0] m_request,
    input  logic [NUM_MASTERS-1:0] m_slave_sel,
    input  logic                   trans_done,
    input  logic [NUM_SLAVES-1:0]  s_split_en,
    output logic [NUM_MASTERS-1:0] m_grant,
    output logic [GW-1:0]          bus_grant,
    output logic [ADDR_BITS-1:0]   slave_sel,
    output logic                   arbiter_busy,
    output logic                   bus_busy,
    output logic                   split_active
);
    localparam int IW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int NSLOT = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_BUSY, S_SPLIT_WAIT, S_SPLIT_ADDR, S_SPLIT_BUSY
    } state_t;

    state_t                 state, state_nx;
    logic [IW-1:0]          win, win_nx;
    logic [ADDR_BITS-1:0]   addr_q, addr_nx;
    logic [2:0]             bit_cnt, cnt_nx;
    logic [IW-1:0]          rr_ptr, ptr_nx;
    logic [IW-1:0]          saved_m, sm_nx;
    logic [ADDR_BITS-1:0]   saved_s, ss_nx;
    logic [NUM_MASTERS-1:0] grant_nx;
    logic [GW-1:0]          bgrant_nx;
    logic [ADDR_BITS-1:0]   sel_nx;
    logic                   abusy_nx, bbusy_nx, split_nx;

    function automatic logic [ADDR_BITS-1:0] shift_in(input logic [ADDR_BITS-1:0] a, input logic b);
        return (a >> 1) | (ADDR_BITS'(b) << (ADDR_BITS - 1));
    endfunction

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IW-1:0] i);
        logic [NUM_MASTERS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
        return (i == IW'(NUM_MASTERS - 1)) ? '0 : i + IW'(1);
    endfunction

    // The saved (split) master never competes while its context is parked.
    logic [NUM_MASTERS-1:0]   req_eff;
    logic [2*NUM_MASTERS-1:0] req_rot;
    logic [IW-1:0]            ptr_eff;
    logic                     pick_vld;
    logic [IW:0]              pick_sum;
    logic [IW-1:0]            pick_idx;

    always_comb begin
        req_eff = m_request;
        if (state == S_SPLIT_WAIT) req_eff[saved_m] = 1'b0;
        ptr_eff  = (RR_MODE != 0) ? rr_ptr : '0;
        req_rot  = {req_eff, req_eff} >> ptr_eff;
        pick_vld = 1'b0;
        pick_sum = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_vld = 1'b1;
                pick_sum = {1'b0, ptr_eff} + (IW+1)'(k);
            end
        end
        if (pick_sum >= (IW+1)'(NUM_MASTERS)) pick_sum = pick_sum - (IW+1)'(NUM_MASTERS);
        pick_idx = pick_sum[IW-1:0];
    end

    // Slave indices at or above NUM_SLAVES read as "no split".
    logic [NSLOT-1:0] split_pad;
    always_comb begin
        split_pad                 = '0;
        split_pad[NUM_SLAVES-1:0] = s_split_en;
    end

    logic [ADDR_BITS-1:0] a_acc, a_cur, g_a;
    logic [IW-1:0]        g_m;
    logic                 last_bit, do_grant, do_clear;

    always_comb begin
        state_nx  = state;
        win_nx    = win;
        addr_nx   = addr_q;
        cnt_nx    = bit_cnt;
        ptr_nx    = rr_ptr;
        sm_nx     = saved_m;
        ss_nx     = saved_s;
        grant_nx  = m_grant;
        bgrant_nx = bus_grant;
        sel_nx    = slave_sel;
        abusy_nx  = arbiter_busy;
        bbusy_nx  = bus_busy;
        split_nx  = split_active;
        do_grant  = 1'b0;
        do_clear  = 1'b0;
        g_m       = '0;
        g_a       = '0;
        a_acc     = shift_in('0, m_slave_sel[pick_idx]);
        a_cur     = shift_in(addr_q, m_slave_sel[win]);
        last_bit  = (bit_cnt == 3'(ADDR_BITS - 1));

        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    if (ADDR_BITS == 1) begin
                        do_grant = 1'b1; g_m = pick_idx; g_a = a_acc;
                        state_nx = S_BUSY;
                    end else begin
                        win_nx = pick_idx; addr_nx = a_acc; cnt_nx = 3'd1;
                        abusy_nx = 1'b1;
                        state_nx = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (!m_request[win]) begin
                    abusy_nx = 1'b0;
                    state_nx = S_IDLE;
                end else begin
                    addr_nx = a_cur;
                    cnt_nx  = bit_cnt + 3'd1;
                    if (last_bit) begin
                        do_grant = 1'b1; g_m = win; g_a = a_cur;
                        state_nx = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (trans_done) begin
                    do_clear = 1'b1;
                    if (RR_MODE != 0) ptr_nx = next_ptr(win);
                    state_nx = S_IDLE;
                end else if (split_pad[slave_sel]) begin
                    sm_nx    = win;
                    ss_nx    = slave_sel;
                    do_clear = 1'b1;
                    split_nx = 1'b1;
                    state_nx = S_SPLIT_WAIT;
                end
            end
            S_SPLIT_WAIT: begin
                if (!split_pad[saved_s]) begin
                    do_grant = 1'b1; g_m = saved_m; g_a = saved_s;
                    split_nx = 1'b0;
                    state_nx = S_BUSY;
                end else if (pick_vld) begin
                    if (ADDR_BITS == 1) begin
                        if (a_acc != saved_s) begin
                            do_grant = 1'b1; g_m = pick_idx; g_a = a_acc;
                            state_nx = S_SPLIT_BUSY;
                        end
                    end else begin
                        win_nx = pick_idx; addr_nx = a_acc; cnt_nx = 3'd1;
                        abusy_nx = 1'b1;
                        state_nx = S_SPLIT_ADDR;
                    end
                end
            end
            S_SPLIT_ADDR: begin
                if (!m_request[win]) begin
                    abusy_nx = 1'b0;
                    state_nx = S_SPLIT_WAIT;
                end else begin
                    addr_nx = a_cur;
                    cnt_nx  = bit_cnt + 3'd1;
                    if (last_bit) begin
                        if (a_cur == saved_s) begin
                            abusy_nx = 1'b0;
                            state_nx = S_SPLIT_WAIT;
                        end else begin
                            do_grant = 1'b1; g_m = win; g_a = a_cur;
                            state_nx = S_SPLIT_BUSY;
                        end
                    end
                end
            end
            S_SPLIT_BUSY: begin
                if (trans_done) begin
                    if (RR_MODE != 0) ptr_nx = next_ptr(win);
                    do_grant = 1'b1; g_m = saved_m; g_a = saved_s;
                    split_nx = 1'b0;
                    state_nx = S_BUSY;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (do_clear) begin
            grant_nx  = '0;
            bgrant_nx = '0;
            sel_nx    = '0;
            bbusy_nx  = 1'b0;
        end
        if (do_grant) begin
            win_nx    = g_m;
            grant_nx  = onehot(g_m);
            bgrant_nx = GW'(g_m) + GW'(1);
            sel_nx    = g_a;
            abusy_nx  = 1'b0;
            bbusy_nx  = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= S_IDLE;
            win          <= '0;
            addr_q       <= '0;
            bit_cnt      <= '0;
            rr_ptr       <= '0;
            saved_m      <= '0;
            saved_s      <= '0;
            m_grant      <= '0;
            bus_grant    <= '0;
            slave_sel    <= '0;
            arbiter_busy <= 1'b0;
            bus_busy     <= 1'b0;
            split_active <= 1'b0;
        end else begin
            state        <= state_nx;
            win          <= win_nx;
            addr_q       <= addr_nx;
            bit_cnt      <= cnt_nx;
            rr_ptr       <= ptr_nx;
            saved_m      <= sm_nx;
            saved_s      <= ss_nx;
            m_grant      <= grant_nx;
            bus_grant    <= bgrant_nx;
            slave_sel    <= sel_nx;
            arbiter_busy <= abusy_nx;
            bus_busy     <= bbusy_nx;
            split_active <= split_nx;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Directed bench: fixed-priority 2-master arbiter with splits, plus a 4-master round-robin instance.
module tb_bus_arbiter_nm;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    // Fixed-priority instance: 2 masters, 3 slaves, 2 address bits.
    logic [1:0] req2 = '0, ssel2 = '0, grant2, bg2, sel2;
    logic [2:0] split2 = '0;
    logic       td2 = 1'b0, abusy2, bbusy2, sact2;

    // Round-robin instance: 4 masters.
    logic [3:0] rreq = '0, rssel = '0, rgrant;
    logic [2:0] rsplit = '0, rbg;
    logic [1:0] rsel;
    logic       rtd = 1'b0, rabusy, rbbusy, rsact;

    int checks = 0;
    int failures = 0;

    bus_arbiter_nm #(.NUM_MASTERS(2), .NUM_SLAVES(3), .ADDR_BITS(2), .RR_MODE(0)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .m_request(req2), .m_slave_sel(ssel2),
        .trans_done(td2), .s_split_en(split2), .m_grant(grant2), .bus_grant(bg2),
        .slave_sel(sel2), .arbiter_busy(abusy2), .bus_busy(bbusy2), .split_active(sact2));

    bus_arbiter_nm #(.NUM_MASTERS(4), .NUM_SLAVES(3), .ADDR_BITS(2), .RR_MODE(1)) dut_rr (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .m_request(rreq), .m_slave_sel(rssel),
        .trans_done(rtd), .s_split_en(rsplit), .m_grant(rgrant), .bus_grant(rbg),
        .slave_sel(rsel), .arbiter_busy(rabusy), .bus_busy(rbbusy), .split_active(rsact));

    // Fixed-instance output vector: {m_grant, bus_grant, slave_sel, arbiter_busy, bus_busy, split_active}
    wire [8:0]  obs2 = {grant2, bg2, sel2, abusy2, bbusy2, sact2};
    wire [11:0] obsr = {rgrant, rbg, rsel, rabusy, rbbusy, rsact};

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if (obs2 !== 9'b0) begin
            failures++;
            $display("FAIL reset_fixed: got %b expected %b", obs2, 9'b0);
        end
        checks++;
        if (obsr !== 12'b0) begin
            failures++;
            $display("FAIL reset_rr: got %b expected %b", obsr, 12'b0);
        end
        sys_rst = 1'b0;
        step();
    endtask

    task automatic test_fixed_priority();
        req2 = 2'b11; ssel2 = 2'b01;
        step();
        checks++;
        if (obs2 !== {2'b00, 2'd0, 2'b00, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL fp_accept: got %b expected %b", obs2, {2'b00, 2'd0, 2'b00, 1'b1, 1'b0, 1'b0});
        end
        ssel2 = 2'b00;
        step();
        checks++;
        if (obs2 !== {2'b01, 2'd1, 2'b01, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL fp_grant_m0: got %b expected %b", obs2, {2'b01, 2'd1, 2'b01, 1'b0, 1'b1, 1'b0});
        end
        td2 = 1'b1; req2 = 2'b10;
        step();
        td2 = 1'b0;
        checks++;
        if (obs2 !== 9'b0) begin
            failures++;
            $display("FAIL fp_done: got %b expected %b", obs2, 9'b0);
        end
        step();
        checks++;
        if (abusy2 !== 1'b1) begin
            failures++;
            $display("FAIL fp_accept_m1: got %b expected %b", abusy2, 1'b1);
        end
        ssel2 = 2'b10;
        step();
        checks++;
        if (obs2 !== {2'b10, 2'd2, 2'b10, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL fp_grant_m1: got %b expected %b", obs2, {2'b10, 2'd2, 2'b10, 1'b0, 1'b1, 1'b0});
        end
        td2 = 1'b1; req2 = 2'b00; ssel2 = 2'b00;
        step();
        td2 = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [2:0] exp_b;
        rreq = 4'b1111; rssel = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            step();
            exp_g = 4'b0001 << (i % 4);
            exp_b = 3'((i % 4) + 1);
            checks++;
            if ({rgrant, rbg, rbbusy} !== {exp_g, exp_b, 1'b1}) begin
                failures++;
                $display("FAIL rr_grant_%0d: got %b expected %b", i, {rgrant, rbg, rbbusy}, {exp_g, exp_b, 1'b1});
            end
            rtd = 1'b1;
            if (i == 4) rreq = 4'b0000;
            step();
            rtd = 1'b0;
        end
    endtask

    // Leaves m0 parked on slave 1 and the fixed instance in SPLIT_WAIT.
    task automatic park_m0_on_slave1();
        req2 = 2'b01; ssel2 = 2'b01;
        step();
        ssel2 = 2'b00;
        step();
        split2 = 3'b010; req2 = 2'b00;
        step();
    endtask

    task automatic test_split();
        park_m0_on_slave1();
        checks++;
        if (obs2 !== {2'b00, 2'd0, 2'b00, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL split_enter: got %b expected %b", obs2, {2'b00, 2'd0, 2'b00, 1'b0, 1'b0, 1'b1});
        end
        req2 = 2'b10; ssel2 = 2'b00;
        step();
        checks++;
        if (obs2 !== {2'b00, 2'd0, 2'b00, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL split_accept_m1: got %b expected %b", obs2, {2'b00, 2'd0, 2'b00, 1'b1, 1'b0, 1'b1});
        end
        ssel2 = 2'b10;
        step();
        checks++;
        if (obs2 !== {2'b10, 2'd2, 2'b10, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL split_grant_m1: got %b expected %b", obs2, {2'b10, 2'd2, 2'b10, 1'b0, 1'b1, 1'b1});
        end
        td2 = 1'b1; req2 = 2'b00; ssel2 = 2'b00; split2 = 3'b000;
        step();
        td2 = 1'b0;
        checks++;
        if (obs2 !== {2'b01, 2'd1, 2'b01, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL split_restore: got %b expected %b", obs2, {2'b01, 2'd1, 2'b01, 1'b0, 1'b1, 1'b0});
        end
        td2 = 1'b1;
        step();
        td2 = 1'b0;
    endtask

    task automatic test_split_conflict();
        park_m0_on_slave1();
        req2 = 2'b10; ssel2 = 2'b10;
        step();
        ssel2 = 2'b00;
        step();
        checks++;
        if (obs2 !== {2'b00, 2'd0, 2'b00, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL conflict_no_grant: got %b expected %b", obs2, {2'b00, 2'd0, 2'b00, 1'b0, 1'b0, 1'b1});
        end
        req2 = 2'b00; split2 = 3'b000;
        step();
        checks++;
        if (obs2 !== {2'b01, 2'd1, 2'b01, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL conflict_restore: got %b expected %b", obs2, {2'b01, 2'd1, 2'b01, 1'b0, 1'b1, 1'b0});
        end
        td2 = 1'b1;
        step();
        td2 = 1'b0;
    endtask

    task automatic test_done_beats_split();
        req2 = 2'b01; ssel2 = 2'b01;
        step();
        ssel2 = 2'b00;
        step();
        td2 = 1'b1; split2 = 3'b010; req2 = 2'b00;
        step();
        td2 = 1'b0;
        checks++;
        if (obs2 !== 9'b0) begin
            failures++;
            $display("FAIL done_vs_split: got %b expected %b", obs2, 9'b0);
        end
        split2 = 3'b000;
        step();
    endtask

    task automatic test_withdraw();
        req2 = 2'b01; ssel2 = 2'b00;
        step();
        req2 = 2'b00;
        step();
        checks++;
        if (obs2 !== 9'b0) begin
            failures++;
            $display("FAIL withdraw_abort: got %b expected %b", obs2, 9'b0);
        end
        step();
        checks++;
        if (obs2 !== 9'b0) begin
            failures++;
            $display("FAIL withdraw_stays_idle: got %b expected %b", obs2, 9'b0);
        end
    endtask

    task automatic test_reset_mid_split();
        park_m0_on_slave1();
        req2 = 2'b10; ssel2 = 2'b00;
        step();
        ssel2 = 2'b10;
        step();
        checks++;
        if (obs2 !== {2'b10, 2'd2, 2'b10, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL rst_setup: got %b expected %b", obs2, {2'b10, 2'd2, 2'b10, 1'b0, 1'b1, 1'b1});
        end
        #2 sys_rst = 1'b1;
        #1;
        checks++;
        if (obs2 !== 9'b0) begin
            failures++;
            $display("FAIL rst_async: got %b expected %b", obs2, 9'b0);
        end
        req2 = 2'b10; ssel2 = 2'b00; split2 = 3'b000;
        rreq = 4'b1111; rssel = 4'b0000;
        #1 sys_rst = 1'b0;
        step();
        step();
        checks++;
        if (obs2 !== {2'b10, 2'd2, 2'b00, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rst_rearb_fixed: got %b expected %b", obs2, {2'b10, 2'd2, 2'b00, 1'b0, 1'b1, 1'b0});
        end
        checks++;
        if (obsr !== {4'b0001, 3'd1, 2'b00, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rst_rr_ptr0: got %b expected %b", obsr, {4'b0001, 3'd1, 2'b00, 1'b0, 1'b1, 1'b0});
        end
        req2 = 2'b00; rreq = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_split();
        test_split_conflict();
        test_done_beats_split();
        test_withdraw();
        test_reset_mid_split();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
